// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with data-memory req/ready handshake and MEM/WB register.
// Requests not answered immediately are latched so a forwarded store value survives the stall.
module mem_stage_lsu #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEM_valid,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [2:0]  MEM_funct3,
    input  logic [31:0] MEM_alu_result,
    input  logic [31:0] MEM_rs2_data,
    input  logic [4:0]  MEM_rd,
    input  logic        MEM_RegWrite,
    input  logic        MEM_WBSrc,
    input  logic        MEM_Fwd_Sig,
    input  logic [31:0] WB_wb_data,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    output logic        MEM_stall,
    output logic        WB_valid,
    output logic        WB_RegWrite,
    output logic        WB_WBSrc,
    output logic [4:0]  WB_rd,
    output logic [31:0] WB_mem_data,
    output logic [31:0] WB_alu_result,
    output logic        WB_misaligned,
    output logic        WB_bus_err
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q;
    logic [7:0]  waitCnt_q;
    logic [31:0] reqAddr_q;
    logic [31:0] reqWdata_q;
    logic [3:0]  reqBe_q;
    logic        reqWe_q;
    logic [2:0]  reqFunct3_q;

    logic        wbValid_q;
    logic        wbRegWrite_q;
    logic        wbWBSrc_q;
    logic [4:0]  wbRd_q;
    logic [31:0] wbMemData_q;
    logic [31:0] wbAluResult_q;
    logic        wbMisaligned_q;
    logic        wbBusErr_q;

    logic        memOp;
    logic        misaligned;
    logic        issueNow;
    logic        inWait;
    logic        timeout;
    logic        stall;
    logic [31:0] storeData;
    logic [3:0]  curBe;
    logic [31:0] curWdata;
    logic [1:0]  selOff;
    logic [2:0]  selFunct3;
    logic        selIsLoad;
    logic [31:0] rawLane;
    logic [31:0] loadValue;

    assign memOp      = MEM_valid & (MEM_MemRead | MEM_MemWrite);
    assign inWait     = (state_q == WAIT);
    assign misaligned = memOp & (((MEM_funct3[1:0] == 2'b01) & MEM_alu_result[0]) |
                                 (MEM_funct3[1] & (MEM_alu_result[1:0] != 2'b00)));
    assign storeData  = MEM_Fwd_Sig ? WB_wb_data : MEM_rs2_data;
    assign issueNow   = (state_q == IDLE) & memOp & ~misaligned;
    assign timeout    = inWait & (waitCnt_q == 8'(MAX_WAIT - 1));

    always_comb begin
        curBe    = 4'b1111;
        curWdata = storeData;
        if (MEM_MemWrite) begin
            case (MEM_funct3[1:0])
                2'b00: begin
                    curBe    = 4'b0001 << MEM_alu_result[1:0];
                    curWdata = {4{storeData[7:0]}};
                end
                2'b01: begin
                    curBe    = MEM_alu_result[1] ? 4'b1100 : 4'b0011;
                    curWdata = {2{storeData[15:0]}};
                end
                default: begin
                    curBe    = 4'b1111;
                    curWdata = storeData;
                end
            endcase
        end
    end

    // While waiting, the bus is fed only from the latched request; live MEM inputs may have moved on.
    assign dmem_req   = issueNow | (inWait & ~timeout);
    assign dmem_we    = inWait ? reqWe_q    : MEM_MemWrite;
    assign dmem_addr  = inWait ? {reqAddr_q[31:2], 2'b00} : {MEM_alu_result[31:2], 2'b00};
    assign dmem_be    = inWait ? reqBe_q    : curBe;
    assign dmem_wdata = inWait ? reqWdata_q : curWdata;

    assign stall     = (issueNow & ~dmem_ready) | (inWait & ~dmem_ready & ~timeout);
    assign MEM_stall = stall;

    assign selOff    = inWait ? reqAddr_q[1:0] : MEM_alu_result[1:0];
    assign selFunct3 = inWait ? reqFunct3_q    : MEM_funct3;
    assign selIsLoad = inWait ? (~reqWe_q & ~timeout) : (issueNow & ~MEM_MemWrite);
    assign rawLane   = dmem_rdata >> {selOff, 3'b000};

    always_comb begin
        loadValue = rawLane;
        case (selFunct3)
            3'b000:  loadValue = {{24{rawLane[7]}}, rawLane[7:0]};
            3'b001:  loadValue = {{16{rawLane[15]}}, rawLane[15:0]};
            3'b100:  loadValue = {24'd0, rawLane[7:0]};
            3'b101:  loadValue = {16'd0, rawLane[15:0]};
            default: loadValue = rawLane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            waitCnt_q   <= 8'd0;
            reqAddr_q   <= 32'd0;
            reqWdata_q  <= 32'd0;
            reqBe_q     <= 4'd0;
            reqWe_q     <= 1'b0;
            reqFunct3_q <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issueNow & ~dmem_ready) begin
                        state_q     <= WAIT;
                        waitCnt_q   <= 8'd0;
                        reqAddr_q   <= MEM_alu_result;
                        reqWdata_q  <= curWdata;
                        reqBe_q     <= curBe;
                        reqWe_q     <= MEM_MemWrite;
                        reqFunct3_q <= MEM_funct3;
                    end
                end
                WAIT: begin
                    if (dmem_ready | timeout) begin
                        state_q   <= IDLE;
                        waitCnt_q <= 8'd0;
                    end else begin
                        waitCnt_q <= waitCnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A stalled cycle inserts a bubble into WB; otherwise the MEM fields advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbValid_q      <= 1'b0;
            wbRegWrite_q   <= 1'b0;
            wbWBSrc_q      <= 1'b0;
            wbRd_q         <= 5'd0;
            wbMemData_q    <= 32'd0;
            wbAluResult_q  <= 32'd0;
            wbMisaligned_q <= 1'b0;
            wbBusErr_q     <= 1'b0;
        end else if (stall) begin
            wbValid_q      <= 1'b0;
            wbRegWrite_q   <= 1'b0;
            wbMisaligned_q <= 1'b0;
            wbBusErr_q     <= 1'b0;
        end else begin
            wbValid_q      <= MEM_valid;
            wbRegWrite_q   <= MEM_valid & MEM_RegWrite & ~(misaligned & ~inWait) & ~timeout;
            wbWBSrc_q      <= MEM_WBSrc;
            wbRd_q         <= MEM_rd;
            wbMemData_q    <= selIsLoad ? loadValue : 32'd0;
            wbAluResult_q  <= MEM_alu_result;
            wbMisaligned_q <= misaligned & ~inWait;
            wbBusErr_q     <= timeout;
        end
    end

    assign WB_valid      = wbValid_q;
    assign WB_RegWrite   = wbRegWrite_q;
    assign WB_WBSrc      = wbWBSrc_q;
    assign WB_rd         = wbRd_q;
    assign WB_mem_data   = wbMemData_q;
    assign WB_alu_result = wbAluResult_q;
    assign WB_misaligned = wbMisaligned_q;
    assign WB_bus_err    = wbBusErr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and randomized transactions against a per-transaction behavioural model.
module tb_mem_stage_lsu;

    localparam int MAX_WAIT = 4;

    logic        clk;
    logic        rst_n;
    logic        MEM_valid;
    logic        MEM_MemRead;
    logic        MEM_MemWrite;
    logic [2:0]  MEM_funct3;
    logic [31:0] MEM_alu_result;
    logic [31:0] MEM_rs2_data;
    logic [4:0]  MEM_rd;
    logic        MEM_RegWrite;
    logic        MEM_WBSrc;
    logic        MEM_Fwd_Sig;
    logic [31:0] WB_wb_data;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        MEM_stall;
    logic        WB_valid;
    logic        WB_RegWrite;
    logic        WB_WBSrc;
    logic [4:0]  WB_rd;
    logic [31:0] WB_mem_data;
    logic [31:0] WB_alu_result;
    logic        WB_misaligned;
    logic        WB_bus_err;

    int checks = 0;
    int failures = 0;

    mem_stage_lsu #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .MEM_valid(MEM_valid), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .MEM_funct3(MEM_funct3), .MEM_alu_result(MEM_alu_result), .MEM_rs2_data(MEM_rs2_data),
        .MEM_rd(MEM_rd), .MEM_RegWrite(MEM_RegWrite), .MEM_WBSrc(MEM_WBSrc),
        .MEM_Fwd_Sig(MEM_Fwd_Sig), .WB_wb_data(WB_wb_data),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .MEM_stall(MEM_stall),
        .WB_valid(WB_valid), .WB_RegWrite(WB_RegWrite), .WB_WBSrc(WB_WBSrc), .WB_rd(WB_rd),
        .WB_mem_data(WB_mem_data), .WB_alu_result(WB_alu_result),
        .WB_misaligned(WB_misaligned), .WB_bus_err(WB_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", tag, actual, expected);
        end
    endtask

    // Load result from the byte-lane rules using plain integer arithmetic.
    function automatic logic [31:0] expLoad(input logic [2:0] f3, input int off, input logic [31:0] rdata);
        longint w;
        w = longint'(rdata) / (longint'(1) << (8 * off));
        case (f3)
            3'b000: begin w = w % 256;   if (w >= 128)   w = w - 256;   end
            3'b001: begin w = w % 65536; if (w >= 32768) w = w - 65536; end
            3'b100: w = w % 256;
            3'b101: w = w % 65536;
            default: ;
        endcase
        return 32'(w);
    endfunction

    task automatic applyStimulus(input logic valid, input logic isRead, input logic isWrite,
                                 input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                                 input logic fwd, input logic [31:0] wbd, input logic [4:0] rd,
                                 input logic regw, input logic wbsrc, input int lat,
                                 input logic [31:0] rdata);
        int size, off, doneCycle;
        logic memop, mis, issue, timedOut;
        logic [31:0] sd, expWd, expAddr, expMem;
        logic [3:0] expBe;
        memop = valid && (isRead || isWrite);
        size = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        off = int'(addr % 4);
        mis = memop && ((addr % size) != 0);
        issue = memop && !mis;
        sd = fwd ? wbd : rs2;
        expAddr = addr - (addr % 4);
        expBe = 4'hF;
        expWd = sd;
        if (isWrite && size == 1) begin
            expBe = 4'(1 << off);
            expWd = (sd % 256) * 32'h01010101;
        end else if (isWrite && size == 2) begin
            expBe = (off >= 2) ? 4'hC : 4'h3;
            expWd = (sd % 65536) * 32'h00010001;
        end
        timedOut = issue && (lat >= MAX_WAIT);
        doneCycle = !issue ? 0 : (timedOut ? MAX_WAIT : lat);
        expMem = (issue && isRead && !isWrite && !timedOut) ? expLoad(f3, off, rdata) : 32'd0;
        for (int c = 0; c <= doneCycle; c++) begin
            @(negedge clk);
            MEM_valid = valid; MEM_MemRead = isRead; MEM_MemWrite = isWrite; MEM_funct3 = f3;
            MEM_alu_result = addr; MEM_rd = rd; MEM_RegWrite = regw; MEM_WBSrc = wbsrc;
            MEM_Fwd_Sig = fwd;
            MEM_rs2_data = (c == 0) ? rs2 : $urandom;
            WB_wb_data   = (c == 0) ? wbd : $urandom;
            if (issue) dmem_ready = (c == lat);
            else       dmem_ready = 1'($urandom_range(0, 1));
            dmem_rdata = (c == lat) ? rdata : $urandom;
            #1;
            checkOutput("dmem_req", 32'(dmem_req), 32'(issue && c < MAX_WAIT));
            checkOutput("MEM_stall", 32'(MEM_stall), 32'(issue && c < doneCycle));
            if (issue && c < MAX_WAIT) begin
                checkOutput("dmem_addr", dmem_addr, expAddr);
                checkOutput("dmem_we", 32'(dmem_we), 32'(isWrite));
                checkOutput("dmem_be", 32'(dmem_be), 32'(expBe));
                if (isWrite) checkOutput("dmem_wdata", dmem_wdata, expWd);
            end
            @(posedge clk);
            #1;
            if (c < doneCycle) begin
                checkOutput("bubble_valid", 32'(WB_valid), 32'd0);
                checkOutput("bubble_regwrite", 32'(WB_RegWrite), 32'd0);
            end else begin
                checkOutput("WB_valid", 32'(WB_valid), 32'(valid));
                checkOutput("WB_RegWrite", 32'(WB_RegWrite), 32'(valid && regw && !mis && !timedOut));
                checkOutput("WB_rd", 32'(WB_rd), 32'(rd));
                checkOutput("WB_alu_result", WB_alu_result, addr);
                checkOutput("WB_WBSrc", 32'(WB_WBSrc), 32'(wbsrc));
                checkOutput("WB_mem_data", WB_mem_data, expMem);
                checkOutput("WB_misaligned", 32'(WB_misaligned), 32'(mis));
                checkOutput("WB_bus_err", 32'(WB_bus_err), 32'(timedOut));
            end
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_req"}, 32'(dmem_req), 32'd0);
        checkOutput({tag, "_stall"}, 32'(MEM_stall), 32'd0);
        checkOutput({tag, "_wb_ctrl"},
                    32'({WB_valid, WB_RegWrite, WB_WBSrc, WB_misaligned, WB_bus_err, WB_rd}), 32'd0);
        checkOutput({tag, "_wb_mem"}, WB_mem_data, 32'd0);
        checkOutput({tag, "_wb_alu"}, WB_alu_result, 32'd0);
    endtask

    initial begin
        logic [2:0] loadCodes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst_n = 1'b0; MEM_valid = 1'b0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
        MEM_funct3 = 3'd0; MEM_alu_result = 32'd0; MEM_rs2_data = 32'd0; MEM_rd = 5'd0;
        MEM_RegWrite = 1'b0; MEM_WBSrc = 1'b0; MEM_Fwd_Sig = 1'b0; WB_wb_data = 32'd0;
        dmem_ready = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Forwarded SW, byte store, signed/unsigned loads, stalled store, misaligned and timeout.
        applyStimulus(1, 0, 1, 3'b010, 32'h100,  32'h0,        1, 32'hDEADBEEF, 5'd5, 0, 0, 0, 32'h0);
        applyStimulus(1, 0, 1, 3'b000, 32'h1003, 32'h123456AB, 0, 32'h0,        5'd0, 0, 0, 0, 32'h0);
        applyStimulus(1, 1, 0, 3'b000, 32'h2001, 32'h0, 0, 32'h0, 5'd7, 1, 1, 0, 32'h00008000);
        applyStimulus(1, 1, 0, 3'b100, 32'h2001, 32'h0, 0, 32'h0, 5'd7, 1, 1, 0, 32'h00008000);
        applyStimulus(1, 1, 0, 3'b001, 32'h2002, 32'h0, 0, 32'h0, 5'd8, 1, 1, 0, 32'h80011234);
        applyStimulus(1, 0, 1, 3'b010, 32'h104,  32'h0, 1, 32'hDEADBEEF, 5'd0, 0, 0, 3, 32'h0);
        applyStimulus(1, 1, 0, 3'b010, 32'h2002, 32'h0, 0, 32'h0, 5'd9, 1, 1, 0, 32'h0);
        applyStimulus(1, 1, 0, 3'b010, 32'h2000, 32'h0, 0, 32'h0, 5'd9, 1, 1, 100, 32'h0);

        // Reset while a store is waiting abandons it.
        @(negedge clk);
        MEM_valid = 1'b1; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b1; MEM_funct3 = 3'b010;
        MEM_alu_result = 32'h300; MEM_RegWrite = 1'b0; dmem_ready = 1'b0;
        #1;
        checkOutput("pre_reset_stall", 32'(MEM_stall), 32'd1);
        @(negedge clk);
        rst_n = 1'b0; MEM_valid = 1'b0;
        @(posedge clk);
        #1;
        checkResetState("midwait_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("after_reset_req", 32'(dmem_req), 32'd0);

        for (int i = 0; i < 80; i++) begin
            int kind, lat;
            logic [2:0] f3;
            logic [31:0] addr;
            kind = $urandom_range(0, 9);
            lat = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
            addr = $urandom;
            if (kind < 4) f3 = loadCodes[$urandom_range(0, 4)];
            else          f3 = 3'($urandom_range(0, 2));
            if (kind < 4)
                applyStimulus(1, 1, 0, f3, addr, $urandom, 1'($urandom), $urandom, 5'($urandom),
                              1'($urandom), 1, lat, $urandom);
            else if (kind < 8)
                applyStimulus(1, 0, 1, f3, addr, $urandom, 1'($urandom), $urandom, 5'($urandom),
                              0, 0, lat, $urandom);
            else
                applyStimulus(1'($urandom), 0, 0, f3, addr, $urandom, 0, $urandom, 5'($urandom),
                              1'($urandom), 0, 0, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
